// File: rtl/voter_session.sv
// voter_session: one ballot session over N_VOTERS with first-vote latching, timeout and registered verdict.
// Optional VOTER_QUORUM_EN adds a no_quorum output and suppresses the verdict below QUORUM votes cast.
module voter_session #(
   parameter int N_VOTERS = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int QUORUM = 3,
   localparam int CNT_W = $clog2(N_VOTERS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_yes,
   output logic                busy,
   output logic                done,
   output logic [N_VOTERS-1:0] voted_mask,
   output logic [CNT_W-1:0]    yes_cnt,
   output logic [CNT_W-1:0]    cast_cnt,
   output logic                res_pass,
   output logic                res_tie,
   output logic                res_fail
`ifdef VOTER_QUORUM_EN
   ,output logic               no_quorum
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_TALLY, S_DONE} state_t;
   state_t r_state, w_next;
   logic [TW-1:0] r_timer;
   logic [N_VOTERS-1:0] w_new, w_mask_nxt;
   logic [CNT_W-1:0] w_new_cnt, w_new_yes;
   logic w_open, w_nq;
   logic [2:0] w_verdict;
   assign busy = (r_state == S_COLLECT) || (r_state == S_TALLY);
   assign w_open = (r_state == S_IDLE) || (r_state == S_DONE);
   always_comb begin
      w_new = vote_valid & ~voted_mask;
      w_mask_nxt = voted_mask | w_new;
      w_new_cnt = '0;
      w_new_yes = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         w_new_cnt = w_new_cnt + CNT_W'(w_new[i]);
         w_new_yes = w_new_yes + CNT_W'(w_new[i] & vote_yes[i]);
      end
   end
`ifdef VOTER_QUORUM_EN
   assign w_nq = int'(cast_cnt) < QUORUM;
`else
   assign w_nq = 1'b0;
`endif
   // {pass, tie, fail}; absentees simply never reach yes_cnt
   assign w_verdict = w_nq ? 3'b000 :
                      (int'(yes_cnt) * 2 > N_VOTERS)  ? 3'b100 :
                      (int'(yes_cnt) * 2 == N_VOTERS) ? 3'b010 : 3'b001;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_next = start ? S_COLLECT : r_state;
         S_COLLECT: w_next = abort ? S_IDLE :
                             (&w_mask_nxt || r_timer == TW'(TIMEOUT_CYC - 1)) ? S_TALLY : S_COLLECT;
         S_TALLY: w_next = abort ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         done <= 1'b0;
         voted_mask <= '0;
         yes_cnt <= '0;
         cast_cnt <= '0;
         {res_pass, res_tie, res_fail} <= 3'b001;
`ifdef VOTER_QUORUM_EN
         no_quorum <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         done <= 1'b0;
         if (w_open && start) begin
            r_timer <= '0;
            voted_mask <= '0;
            yes_cnt <= '0;
            cast_cnt <= '0;
            {res_pass, res_tie, res_fail} <= 3'b000;
`ifdef VOTER_QUORUM_EN
            no_quorum <= 1'b0;
`endif
         end
         if (r_state == S_COLLECT && !abort) begin
            r_timer <= r_timer + 1'b1;
            voted_mask <= w_mask_nxt;
            yes_cnt <= yes_cnt + w_new_yes;
            cast_cnt <= cast_cnt + w_new_cnt;
         end
         if (r_state == S_TALLY && !abort) begin
            done <= 1'b1;
            {res_pass, res_tie, res_fail} <= w_verdict;
`ifdef VOTER_QUORUM_EN
            no_quorum <= w_nq;
`endif
         end
      end
   end
endmodule

// File: tb/tb_voter_session.sv
// tb_voter_session: directed and randomized ballot sessions checked against a first-vote tally model.
module tb_voter_session;
   localparam int N = 4;
   localparam int T = 16;
   localparam int W = $clog2(N + 1);
   logic clk = 1'b0;
   logic rst, start, abort;
   logic [N-1:0] vote_valid, vote_yes;
   logic busy, done, res_pass, res_tie, res_fail;
   logic [N-1:0] voted_mask;
   logic [W-1:0] yes_cnt, cast_cnt;
   int n_chk = 0;
   int n_pass = 0;
   logic [N-1:0] pv[T];
   logic [N-1:0] py[T];
   int ab_at;

   voter_session #(.N_VOTERS(N), .TIMEOUT_CYC(T), .QUORUM(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .vote_valid(vote_valid), .vote_yes(vote_yes),
      .busy(busy), .done(done), .voted_mask(voted_mask),
      .yes_cnt(yes_cnt), .cast_cnt(cast_cnt),
      .res_pass(res_pass), .res_tie(res_tie), .res_fail(res_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_plan();
      for (int k = 0; k < T; k++) begin
         pv[k] = '0;
         py[k] = '0;
      end
      ab_at = -1;
   endtask

   task automatic session(input string nm);
      logic [N-1:0] m;
      int yc, cc;
      bit fin;
      logic [2:0] exp_res;
      m = '0;
      yc = 0;
      cc = 0;
      fin = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      check({nm, ":open_busy"}, busy, 1);
      check({nm, ":open_res"}, {res_pass, res_tie, res_fail}, 0);
      check({nm, ":open_cast"}, cast_cnt, 0);
      for (int k = 0; k < T && !fin; k++) begin
         if (k == ab_at) begin
            abort = 1'b1;
            start = 1'(($urandom_range(0, 1)));
            step();
            abort = 1'b0;
            start = 1'b0;
            check({nm, ":abort_busy"}, busy, 0);
            check({nm, ":abort_done"}, done, 0);
            check({nm, ":abort_res"}, {res_pass, res_tie, res_fail}, 0);
            check({nm, ":abort_cast"}, cast_cnt, cc);
            check({nm, ":abort_mask"}, voted_mask, m);
            step();
            check({nm, ":abort_idle"}, busy, 0);
            return;
         end
         vote_valid = pv[k];
         vote_yes = py[k];
         start = ($urandom_range(0, 7) == 0);
         step();
         for (int i = 0; i < N; i++)
            if (pv[k][i] && !m[i]) begin
               m[i] = 1'b1;
               cc++;
               yc += int'(py[k][i]);
            end
         vote_valid = '0;
         vote_yes = '0;
         start = 1'b0;
         fin = (m == '1) || (k == T - 1);
         check({nm, ":c_busy"}, busy, 1);
         check({nm, ":c_done"}, done, 0);
         check({nm, ":c_cast"}, cast_cnt, cc);
         check({nm, ":c_yes"}, yes_cnt, yc);
      end
      exp_res = (2 * yc > N) ? 3'b100 : (2 * yc == N) ? 3'b010 : 3'b001;
      step();
      check({nm, ":done"}, done, 1);
      check({nm, ":res"}, {res_pass, res_tie, res_fail}, exp_res);
      check({nm, ":yes"}, yes_cnt, yc);
      check({nm, ":cast"}, cast_cnt, cc);
      check({nm, ":mask"}, voted_mask, m);
      check({nm, ":busy_done"}, busy, 0);
      vote_valid = N'($urandom);
      vote_yes = N'($urandom);
      step();
      vote_valid = '0;
      vote_yes = '0;
      check({nm, ":done_pulse"}, done, 0);
      check({nm, ":hold_cast"}, cast_cnt, cc);
      check({nm, ":hold_res"}, {res_pass, res_tie, res_fail}, exp_res);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      vote_valid = '0;
      vote_yes = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mask", voted_mask, 0);
      check("rst_cnt", {yes_cnt, cast_cnt}, 0);
      check("rst_res", {res_pass, res_tie, res_fail}, 3'b001);
      vote_valid = '1;
      vote_yes = '1;
      step();
      vote_valid = '0;
      vote_yes = '0;
      check("idle_ignore", cast_cnt, 0);

      clear_plan();
      pv[0] = 4'b1111; py[0] = 4'b0111;
      session("pass");
      clear_plan();
      pv[0] = 4'b0001; py[0] = 4'b0001;
      pv[1] = 4'b0100; py[1] = 4'b0100;
      pv[2] = 4'b1010;
      session("tie");
      clear_plan();
      pv[0] = 4'b0010; py[0] = 4'b0010;
      session("timeout");
      clear_plan();
      pv[0] = 4'b0001; py[0] = 4'b0001;
      pv[3] = 4'b0001;
      pv[4] = 4'b1110;
      session("revote");
      clear_plan();
      pv[0] = 4'b0001; py[0] = 4'b0001;
      pv[1] = 4'b0100; py[1] = 4'b0100;
      ab_at = 2;
      session("abort");

      start = 1'b1;
      step();
      start = 1'b0;
      vote_valid = 4'b0011;
      vote_yes = 4'b0011;
      step();
      vote_valid = '0;
      vote_yes = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_mask", voted_mask, 0);
      check("mrst_cnt", {yes_cnt, cast_cnt}, 0);
      check("mrst_res", {res_pass, res_tie, res_fail}, 3'b001);

      for (int s = 0; s < 40; s++) begin
         clear_plan();
         for (int k = 0; k < T; k++) begin
            pv[k] = N'($urandom & $urandom & $urandom);
            py[k] = N'($urandom);
         end
         if ($urandom_range(0, 4) == 0) ab_at = $urandom_range(0, T - 1);
         session("rand");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
